// File: rtl/muldiv_if.sv
// ----------------------------------------------------------------------------
// muldiv_if
// Issue/result bundle between the execute stage and the multiply/divide unit.
//   i_start        issue strobe (sampled by the unit only while not busy)
//   i_op           0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//   i_op1, i_op2   rs / rt operands
//   o_busy         operation in flight, execute stage must stall
//   o_done         one-cycle pulse when HI/LO take a mul/div result
//   o_hi, o_lo     architectural HI/LO registers
//   o_div_by_zero  sticky flag from the last DIV/DIVU with a zero divisor
// master = execute stage, slave = muldiv_unit.
// ----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_div_by_zero;

    modport master (
        output i_start, i_op, i_op1, i_op2,
        input  o_busy, o_done, o_hi, o_lo, o_div_by_zero
    );

    modport slave (
        input  i_start, i_op, i_op1, i_op2,
        output o_busy, o_done, o_hi, o_lo, o_div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle integer multiply/divide unit holding the HI/LO pair.
// Executes MULT, MULTU, DIV, DIVU (one bit per cycle, shift-add / restoring
// divide on magnitudes, then one sign fix-up cycle) and MTHI/MTLO (immediate).
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      muldiv_if.slave: issue strobe/op/operands in, busy/done/HI/LO/
//            divide-by-zero flag out
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    muldiv_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t             state_reg, state_next;
    logic [2*WIDTH-1:0] acc_reg;      // mul: {partial, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0]   b_reg;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_reg;    // op1 as issued, for the divide-by-zero HI value
    logic [CNT_W-1:0]   cnt_reg;
    logic               is_div_reg;
    logic               neg_q_reg;    // operand signs differ
    logic               neg_r_reg;    // dividend negative
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               dbz_reg;

    logic               accept;
    logic               is_signed, s1, s2;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub, div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // DONE behaves like IDLE for issue so back-to-back operations lose no cycle.
    assign accept    = bus.i_start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign is_signed = ~bus.i_op[0];
    assign s1        = is_signed & bus.i_op1[WIDTH-1];
    assign s2        = is_signed & bus.i_op2[WIDTH-1];
    assign abs1      = s1 ? -bus.i_op1 : bus.i_op1;
    assign abs2      = s2 ? -bus.i_op2 : bus.i_op2;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit (LSB) is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? b_reg : '0)};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder stays below the
    // divisor, so the shifted value never needs more than WIDTH+1 bits.
    assign div_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, b_reg});
    assign div_sub  = div_sh[WIDTH-1:0] - b_reg;
    assign div_rem  = div_ge ? div_sub : div_sh[WIDTH-1:0];
    assign div_next = {div_rem, acc_reg[WIDTH-2:0], div_ge};

    assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    assign quo_fix  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (accept && !bus.i_op[2]) begin
                    state_next = bus.i_op[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_reg == LAST) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_reg    <= '0;
            b_reg      <= '0;
            a_raw_reg  <= '0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dbz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        case (bus.i_op)
                            3'd4: hi_reg <= bus.i_op1;
                            3'd5: lo_reg <= bus.i_op1;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                // Divide keeps the dividend in the low half;
                                // multiply keeps the multiplier there.
                                acc_reg    <= {{WIDTH{1'b0}}, (bus.i_op[1] ? abs1 : abs2)};
                                b_reg      <= bus.i_op[1] ? abs2 : abs1;
                                a_raw_reg  <= bus.i_op1;
                                cnt_reg    <= '0;
                                is_div_reg <= bus.i_op[1];
                                neg_q_reg  <= s1 ^ s2;
                                neg_r_reg  <= s1;
                                dbz_reg    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_reg != LAST) begin
                        acc_reg <= mul_next;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (cnt_reg != LAST) begin
                        acc_reg <= div_next;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (is_div_reg) begin
                        if (b_reg == '0) begin
                            hi_reg  <= a_raw_reg;
                            lo_reg  <= '1;
                            dbz_reg <= 1'b1;
                        end else begin
                            hi_reg <= rem_fix;
                            lo_reg <= quo_fix;
                        end
                    end else begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy        = (state_reg == ST_MUL) || (state_reg == ST_DIV) || (state_reg == ST_FIX);
    assign bus.o_done        = (state_reg == ST_DONE);
    assign bus.o_hi          = hi_reg;
    assign bus.o_lo          = lo_reg;
    assign bus.o_div_by_zero = dbz_reg;
endmodule
